// File: rtl/nios_system_rect_fill_if.sv
// Avalon-MM write-master bus between the rectangle filler and the pixel buffer slave port.
interface nios_system_rect_fill_if;
    logic [31:0] m_address;
    logic [15:0] m_writedata;
    logic        m_write;
    logic [1:0]  m_byteenable;
    logic        m_waitrequest;

    modport master (
        output m_address,
        output m_writedata,
        output m_write,
        output m_byteenable,
        input  m_waitrequest
    );

    modport slave (
        input  m_address,
        input  m_writedata,
        input  m_write,
        input  m_byteenable,
        output m_waitrequest
    );
endinterface

// File: rtl/nios_system_rect_fill.sv
// Fills a clipped RGB565 rectangle into the VGA pixel buffer, one Avalon write per pixel,
// started by a rising edge of the go PIO.
module nios_system_rect_fill #(
    parameter logic [31:0] BASE_ADDR = 32'h0800_0000,
    parameter int unsigned SCREEN_W  = 320,
    parameter int unsigned SCREEN_H  = 240
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [15:0]             color,
    input  logic [8:0]              x0,
    input  logic [7:0]              y0,
    input  logic [8:0]              x1,
    input  logic [7:0]              y1,
    input  logic                    go,
    nios_system_rect_fill_if.master m,
    output logic                    busy,
    output logic                    done
);
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    localparam logic [8:0] X_LAST = 9'(SCREEN_W - 1);
    localparam logic [7:0] Y_LAST = 8'(SCREEN_H - 1);

    state_t      state_q;
    logic        go_dly_q;
    logic [15:0] color_q;
    logic [8:0]  xa_q, xb_q, xmin_q, xmax_q, x_q;
    logic [7:0]  ya_q, yb_q, ymin_q, ymax_q, y_q;
    logic [31:0] m_address_q;
    logic [15:0] m_writedata_q;
    logic        m_write_q;
    logic        busy_q;
    logic        done_q;

    logic [8:0]  xlo_d, xhi_d, x_d;
    logic [7:0]  ylo_d, yhi_d, y_d;
    logic        empty_d, last_d;
    logic        trigger;

    // Row pitch is 1024 bytes (512 pixels), pixels are 2 bytes wide.
    function automatic logic [31:0] pix_addr(input logic [8:0] px, input logic [7:0] py);
        return BASE_ADDR + {14'd0, py, 10'd0} + {22'd0, px, 1'b0};
    endfunction

    assign trigger = go & ~go_dly_q;

    always_comb begin
        xlo_d   = (xa_q <= xb_q) ? xa_q : xb_q;
        xhi_d   = (xa_q <= xb_q) ? xb_q : xa_q;
        ylo_d   = (ya_q <= yb_q) ? ya_q : yb_q;
        yhi_d   = (ya_q <= yb_q) ? yb_q : ya_q;
        if (xhi_d > X_LAST) xhi_d = X_LAST;
        if (yhi_d > Y_LAST) yhi_d = Y_LAST;
        empty_d = (xlo_d > X_LAST) || (ylo_d > Y_LAST);
    end

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        last_d = 1'b0;
        if (x_q < xmax_q) begin
            x_d = x_q + 9'd1;
        end else if (y_q < ymax_q) begin
            x_d = xmin_q;
            y_d = y_q + 8'd1;
        end else begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            go_dly_q      <= 1'b0;
            color_q       <= '0;
            xa_q          <= '0;
            xb_q          <= '0;
            ya_q          <= '0;
            yb_q          <= '0;
            xmin_q        <= '0;
            xmax_q        <= '0;
            ymin_q        <= '0;
            ymax_q        <= '0;
            x_q           <= '0;
            y_q           <= '0;
            m_address_q   <= '0;
            m_writedata_q <= '0;
            m_write_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            go_dly_q <= go;
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (trigger) begin
                        color_q <= color;
                        xa_q    <= x0;
                        xb_q    <= x1;
                        ya_q    <= y0;
                        yb_q    <= y1;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    xmin_q <= xlo_d;
                    xmax_q <= xhi_d;
                    ymin_q <= ylo_d;
                    ymax_q <= yhi_d;
                    x_q    <= xlo_d;
                    y_q    <= ylo_d;
                    if (empty_d) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    // First cycle in WRITE presents the first pixel; afterwards the bus
                    // advances only on cycles where the slave accepted the write.
                    if (!m_write_q) begin
                        m_write_q     <= 1'b1;
                        m_address_q   <= pix_addr(x_q, y_q);
                        m_writedata_q <= color_q;
                    end else if (!m.m_waitrequest) begin
                        if (last_d) begin
                            m_write_q <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            x_q         <= x_d;
                            y_q         <= y_d;
                            m_address_q <= pix_addr(x_d, y_d);
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m.m_address    = m_address_q;
    assign m.m_writedata  = m_writedata_q;
    assign m.m_write      = m_write_q;
    assign m.m_byteenable = 2'b11;
    assign busy           = busy_q;
    assign done           = done_q;
endmodule
